// File: rtl/fp_wb_arbiter.sv
// Shares the single FP register-file write port between MEM/WB writeback and
// one buffered long-latency (FDIV/FSQRT) result, with a bounded starvation stall.
module fp_wb_arbiter #(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            pipe_fwr_en_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [FLEN-1:0] pipe_fdata_i,
  input  logic            pipe_fexc_i,
  input  logic            lu_valid_i,
  output logic            lu_ready_o,
  input  logic [4:0]      lu_rd_i,
  input  logic [FLEN-1:0] lu_data_i,
  input  logic            lu_exc_i,
  output logic            stall_o,
  output logic            fwr_en_o,
  output logic [4:0]      fwr_addr_o,
  output logic [FLEN-1:0] fwr_data_o,
  output logic            pending_o,
  output logic [4:0]      pending_rd_o,
  input  logic            exc_clr_i,
  output logic            fexc_sticky_o
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_FORCE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [4:0]        buf_rd_q, buf_rd_d;
  logic [FLEN-1:0]   buf_data_q, buf_data_d;
  logic              fwr_en_q, fwr_en_d;
  logic [4:0]        fwr_addr_q, fwr_addr_d;
  logic [FLEN-1:0]   fwr_data_q, fwr_data_d;
  logic              sticky_q, sticky_d;
  logic              pw, sticky_set;

  assign stall_o       = (state_q == ST_FORCE);
  assign lu_ready_o    = (state_q == ST_IDLE);
  assign pending_o     = (state_q != ST_IDLE);
  assign pending_rd_o  = buf_rd_q;
  assign fwr_en_o      = fwr_en_q;
  assign fwr_addr_o    = fwr_addr_q;
  assign fwr_data_o    = fwr_data_q;
  assign fexc_sticky_o = sticky_q;

  assign pw = pipe_fwr_en_i & ~pipe_fexc_i & ~stall_o;

  // Excepting long-latency results are only accepted while the buffer is free.
  assign sticky_set = (pipe_fwr_en_i & pipe_fexc_i & ~stall_o)
                    | (lu_valid_i & lu_exc_i & lu_ready_o);
  assign sticky_d   = sticky_set | (sticky_q & ~exc_clr_i);

  // Port selection and buffer state machine.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    fwr_en_d   = 1'b0;
    fwr_addr_d = fwr_addr_q;
    fwr_data_d = fwr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pw) begin
          fwr_en_d   = 1'b1;
          fwr_addr_d = pipe_rd_i;
          fwr_data_d = pipe_fdata_i;
        end
        if (lu_valid_i && !lu_exc_i) begin
          buf_rd_d   = lu_rd_i;
          buf_data_d = lu_data_i;
          wait_cnt_d = '0;
          state_d    = ST_HELD;
        end
      end
      ST_HELD: begin
        fwr_en_d = 1'b1;
        if (!pw) begin
          fwr_addr_d = buf_rd_q;
          fwr_data_d = buf_data_q;
          state_d    = ST_IDLE;
        end else begin
          fwr_addr_d = pipe_rd_i;
          fwr_data_d = pipe_fdata_i;
          if (pipe_rd_i == buf_rd_q) begin
            // Younger in-order write supersedes the buffered result.
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
            if (wait_cnt_q == STARVE_LAST) state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        fwr_en_d   = 1'b1;
        fwr_addr_d = buf_rd_q;
        fwr_data_d = buf_data_q;
        wait_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      fwr_en_q   <= 1'b0;
      fwr_addr_q <= '0;
      fwr_data_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      fwr_en_q   <= fwr_en_d;
      fwr_addr_q <= fwr_addr_d;
      fwr_data_q <= fwr_data_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench: a one-entry-buffer reference model predicts each cycle's
// write-port and status outputs; a monitor compares them after every edge.
module tb_fp_wb_arbiter;
  localparam int unsigned FLEN = 32;
  localparam int unsigned SMAX = 4;

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_fwr_en_i = 1'b0, pipe_fexc_i = 1'b0;
  logic [4:0]      pipe_rd_i = '0;
  logic [FLEN-1:0] pipe_fdata_i = '0;
  logic            lu_valid_i = 1'b0, lu_exc_i = 1'b0, exc_clr_i = 1'b0;
  logic [4:0]      lu_rd_i = '0;
  logic [FLEN-1:0] lu_data_i = '0;
  logic            lu_ready_o, stall_o, fwr_en_o, pending_o, fexc_sticky_o;
  logic [4:0]      fwr_addr_o, pending_rd_o;
  logic [FLEN-1:0] fwr_data_o;

  fp_wb_arbiter #(.FLEN(FLEN), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .pipe_fwr_en_i(pipe_fwr_en_i), .pipe_rd_i(pipe_rd_i), .pipe_fdata_i(pipe_fdata_i),
    .pipe_fexc_i(pipe_fexc_i), .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
    .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i), .lu_exc_i(lu_exc_i), .stall_o(stall_o),
    .fwr_en_o(fwr_en_o), .fwr_addr_o(fwr_addr_o), .fwr_data_o(fwr_data_o),
    .pending_o(pending_o), .pending_rd_o(pending_rd_o), .exc_clr_i(exc_clr_i),
    .fexc_sticky_o(fexc_sticky_o));

  always #5 CLK = ~CLK;

  typedef struct {
    logic            en;
    logic [4:0]      addr;
    logic [FLEN-1:0] data;
    logic            pending;
    logic [4:0]      pend_rd;
    logic            stall;
    logic            ready;
    logic            sticky;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: one buffered result and the number of arbitrations it lost.
  logic            m_bvalid;
  logic [4:0]      m_brd;
  logic [FLEN-1:0] m_bdata;
  int              m_losses;
  logic            m_sticky;
  // MEM/WB hold: a request presented during a stall is re-presented next cycle.
  logic            h_valid;
  logic            h_en, h_exc;
  logic [4:0]      h_rd;
  logic [FLEN-1:0] h_data;

  task automatic chk(input string name, input logic [FLEN-1:0] act, input logic [FLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bvalid = 1'b0; m_brd = '0; m_bdata = '0; m_losses = 0; m_sticky = 1'b0;
    h_valid = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus and push the outputs expected after the next edge.
  task automatic step(input logic en, input logic exc, input logic [4:0] rd,
                      input logic [FLEN-1:0] data, input logic luv, input logic lue,
                      input logic [4:0] lurd, input logic [FLEN-1:0] ludata,
                      input logic clr);
    exp_t e;
    logic stall, pw, had_buf;
    @(negedge CLK);
    if (h_valid) begin
      en = h_en; exc = h_exc; rd = h_rd; data = h_data; h_valid = 1'b0;
    end
    pipe_fwr_en_i = en; pipe_fexc_i = exc; pipe_rd_i = rd; pipe_fdata_i = data;
    lu_valid_i = luv; lu_exc_i = lue; lu_rd_i = lurd; lu_data_i = ludata;
    exc_clr_i = clr;
    stall   = m_bvalid && (m_losses == SMAX);
    pw      = en && !exc && !stall;
    had_buf = m_bvalid;
    e.en = 1'b0; e.addr = '0; e.data = '0;
    if (stall) begin
      e.en = 1'b1; e.addr = m_brd; e.data = m_bdata; m_bvalid = 1'b0;
      h_valid = 1'b1; h_en = en; h_exc = exc; h_rd = rd; h_data = data;
    end else if (m_bvalid) begin
      e.en = 1'b1;
      if (!pw) begin
        e.addr = m_brd; e.data = m_bdata; m_bvalid = 1'b0;
      end else begin
        e.addr = rd; e.data = data;
        if (rd == m_brd) m_bvalid = 1'b0;
        else m_losses++;
      end
    end else begin
      if (pw) begin
        e.en = 1'b1; e.addr = rd; e.data = data;
      end
      if (luv && !lue) begin
        m_bvalid = 1'b1; m_brd = lurd; m_bdata = ludata; m_losses = 0;
      end
    end
    if ((en && exc && !stall) || (luv && lue && !had_buf)) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    e.pending = m_bvalid;
    e.pend_rd = m_brd;
    e.stall   = m_bvalid && (m_losses == SMAX);
    e.ready   = !m_bvalid;
    e.sticky  = m_sticky;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the write port presents a (possibly idle) slot after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwr_en", FLEN'(fwr_en_o), FLEN'(e.en));
        if (e.en) begin
          chk("fwr_addr", FLEN'(fwr_addr_o), FLEN'(e.addr));
          chk("fwr_data", fwr_data_o, e.data);
        end
        chk("pending", FLEN'(pending_o), FLEN'(e.pending));
        if (e.pending) chk("pending_rd", FLEN'(pending_rd_o), FLEN'(e.pend_rd));
        chk("stall", FLEN'(stall_o), FLEN'(e.stall));
        chk("lu_ready", FLEN'(lu_ready_o), FLEN'(e.ready));
        chk("sticky", FLEN'(fexc_sticky_o), FLEN'(e.sticky));
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_fwr_en", FLEN'(fwr_en_o), 0);
    chk("rst_fwr_addr", FLEN'(fwr_addr_o), 0);
    chk("rst_fwr_data", fwr_data_o, 0);
    chk("rst_pending", FLEN'(pending_o), 0);
    chk("rst_pending_rd", FLEN'(pending_rd_o), 0);
    chk("rst_stall", FLEN'(stall_o), 0);
    chk("rst_sticky", FLEN'(fexc_sticky_o), 0);
    chk("rst_lu_ready", FLEN'(lu_ready_o), 1);
  endtask

  initial begin
    int drain;
    logic [FLEN-1:0] rdat, ldat;
    logic [4:0] prd, lrd;
    model_reset();
    #12;
    check_reset_values();
    @(negedge CLK);
    rst_n = 1'b1;

    // Single long-latency result into an idle port.
    step(0, 0, 0, 0, 1, 0, 5'd3, 32'h40490FDB, 0);
    idle(3);

    // Starvation: buffered rd 5 against back-to-back pipe writes.
    step(0, 0, 0, 0, 1, 0, 5'd5, 32'hA5A5_0005, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, 5'(i), 32'h1000_0000 + i, 0, 0, 0, 0, 0);
    idle(3);

    // WAW: pipe writes the buffered destination.
    step(0, 0, 0, 0, 1, 0, 5'd9, 32'hDEAD_0009, 0);
    step(1, 0, 5'd9, 32'hBEEF_0009, 0, 0, 0, 0, 0);
    idle(4);

    // Sticky exception set / clear / simultaneous set+clear.
    step(1, 1, 5'd2, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd4, 32'h0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Excepting long-latency result in IDLE is dropped and sets sticky.
    step(0, 0, 0, 0, 1, 1, 5'd6, 32'h1234, 0);
    idle(2);

    // Reset while holding a buffered rd 7.
    step(0, 0, 0, 0, 1, 0, 5'd7, 32'h7777_7777, 0);
    step(1, 0, 5'd8, 32'h8888_8888, 0, 0, 0, 0, 0);
    @(negedge CLK);
    pipe_fwr_en_i = 0; lu_valid_i = 0; exc_clr_i = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    model_reset();
    @(negedge CLK);
    rst_n = 1'b1;
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      prd  = 5'($urandom_range(0, 7));
      lrd  = 5'($urandom_range(0, 7));
      rdat = $urandom;
      ldat = $urandom;
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), prd, rdat,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0), lrd, ldat,
           ($urandom_range(0, 15) == 0));
    end
    idle(4);

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge CLK);
      drain++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
